// File: rtl/wb_arb_pkg.sv
// Shared encodings for the Wishbone core arbiter: grant codes, FSM states, default watchdog length.
// Pure declarations; no logic, no latency.
package wb_arb_pkg;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_I    = 2'b01;
    localparam logic [1:0] GNT_D    = 2'b10;

    localparam int DEF_TIMEOUT_CYCLES = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_GNT_I = 2'b01,
        ST_GNT_D = 2'b10
    } arb_state_t;

endpackage

// File: rtl/wb_arb_timeout.sv
// Bus watchdog: counts enabled cycles without ack and flags expiry on the last allowed cycle.
// Expire is combinational from the count and ack; TIMEOUT_CYCLES=0 never expires.
module wb_arb_timeout
    import wb_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic ack,
    output logic expire
);

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;
    localparam bit ACTIVE = (TIMEOUT_CYCLES > 0);

    logic [CW-1:0] cnt;

    // Saturating count so a very long stall can never wrap back into a false expiry.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en && !ack && (cnt != {CW{1'b1}})) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign expire = ACTIVE && en && !ack && (cnt == LAST);

endmodule

// File: rtl/wb_core_arbiter.sv
// Two-master (I/D) to one-slave Wishbone-classic arbiter; WB_ARB_ROUND_ROBIN_EN selects round-robin over fixed D-first.
// One cycle from sampled request to slave strobe; grant released after every ack, abort or watchdog expiry.
module wb_core_arbiter
    import wb_arb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                    clk_core,
    input  logic                    rst_core,

    input  logic                    i_cyc_i,
    input  logic                    i_stb_i,
    input  logic                    i_we_i,
    input  logic [DATA_WIDTH/8-1:0] i_sel_i,
    input  logic [ADDR_WIDTH-1:0]   i_addr_i,
    input  logic [DATA_WIDTH-1:0]   i_dat_i,
    output logic [DATA_WIDTH-1:0]   i_dat_o,
    output logic                    i_ack_o,
    output logic                    i_err_o,

    input  logic                    d_cyc_i,
    input  logic                    d_stb_i,
    input  logic                    d_we_i,
    input  logic [DATA_WIDTH/8-1:0] d_sel_i,
    input  logic [ADDR_WIDTH-1:0]   d_addr_i,
    input  logic [DATA_WIDTH-1:0]   d_dat_i,
    output logic [DATA_WIDTH-1:0]   d_dat_o,
    output logic                    d_ack_o,
    output logic                    d_err_o,

    output logic                    m_cyc_o,
    output logic                    m_stb_o,
    output logic                    m_we_o,
    output logic [DATA_WIDTH/8-1:0] m_sel_o,
    output logic [ADDR_WIDTH-1:0]   m_addr_o,
    output logic [DATA_WIDTH-1:0]   m_dat_o,
    input  logic [DATA_WIDTH-1:0]   m_dat_i,
    input  logic                    m_ack_i,

    output logic [1:0]              grant_o
);

    arb_state_t state;
    logic       req_i, req_d;
    logic       pick_i, pick_d;
    logic       gnt_i, gnt_d;
    logic       tmo_expire;

    assign req_i = i_cyc_i & i_stb_i;
    assign req_d = d_cyc_i & d_stb_i;
    assign gnt_i = (state == ST_GNT_I);
    assign gnt_d = (state == ST_GNT_D);

`ifdef WB_ARB_ROUND_ROBIN_EN
    // 1 = D was granted most recently; reset value favours D on the first contention.
    logic last_gnt_d;
    assign pick_d = req_d & (~req_i | ~last_gnt_d);
`else
    assign pick_d = req_d;
`endif
    assign pick_i = req_i & ~pick_d;

    always_ff @(posedge clk_core) begin
        if (rst_core) begin
            state <= ST_IDLE;
`ifdef WB_ARB_ROUND_ROBIN_EN
            last_gnt_d <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_d) begin
                        state <= ST_GNT_D;
`ifdef WB_ARB_ROUND_ROBIN_EN
                        last_gnt_d <= 1'b1;
`endif
                    end else if (pick_i) begin
                        state <= ST_GNT_I;
`ifdef WB_ARB_ROUND_ROBIN_EN
                        last_gnt_d <= 1'b0;
`endif
                    end
                end
                ST_GNT_I: begin
                    if (m_ack_i || !i_cyc_i || tmo_expire) begin
                        state <= ST_IDLE;
                    end
                end
                ST_GNT_D: begin
                    if (m_ack_i || !d_cyc_i || tmo_expire) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    wb_arb_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk_core),
        .rst    (rst_core),
        .clr    (state == ST_IDLE),
        .en     (gnt_i | gnt_d),
        .ack    (m_ack_i),
        .expire (tmo_expire)
    );

    // Responses are qualified by the owner's cyc so an ack landing on an abort is dropped.
    always_comb begin
        m_cyc_o  = 1'b0;
        m_stb_o  = 1'b0;
        m_we_o   = 1'b0;
        m_sel_o  = '0;
        m_addr_o = '0;
        m_dat_o  = '0;
        i_ack_o  = 1'b0;
        i_err_o  = 1'b0;
        d_ack_o  = 1'b0;
        d_err_o  = 1'b0;
        grant_o  = GNT_NONE;
        if (gnt_i) begin
            m_cyc_o  = i_cyc_i;
            m_stb_o  = i_stb_i;
            m_we_o   = i_we_i;
            m_sel_o  = i_sel_i;
            m_addr_o = i_addr_i;
            m_dat_o  = i_dat_i;
            i_ack_o  = i_cyc_i & m_ack_i;
            i_err_o  = i_cyc_i & tmo_expire;
            grant_o  = GNT_I;
        end else if (gnt_d) begin
            m_cyc_o  = d_cyc_i;
            m_stb_o  = d_stb_i;
            m_we_o   = d_we_i;
            m_sel_o  = d_sel_i;
            m_addr_o = d_addr_i;
            m_dat_o  = d_dat_i;
            d_ack_o  = d_cyc_i & m_ack_i;
            d_err_o  = d_cyc_i & tmo_expire;
            grant_o  = GNT_D;
        end
    end

    assign i_dat_o = m_dat_i;
    assign d_dat_o = m_dat_i;

endmodule

// File: tb/tb_wb_core_arbiter.sv
// Directed bench for wb_core_arbiter: cycle table for arbitration plus hand sequences for watchdog, abort and reset.
module tb_wb_core_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SW  = DW / 8;
    localparam int TMO = 16;

    localparam logic [1:0] G_NONE = 2'b00;
    localparam logic [1:0] G_I    = 2'b01;
    localparam logic [1:0] G_D    = 2'b10;
`ifdef WB_ARB_ROUND_ROBIN_EN
    localparam logic [1:0] G_ALT  = G_I;
`else
    localparam logic [1:0] G_ALT  = G_D;
`endif

    localparam logic [AW-1:0] I_ADDR = 32'h0000_0100;
    localparam logic [DW-1:0] I_WDAT = 32'h1111_2222;
    localparam logic [SW-1:0] I_SEL  = 4'h3;
    localparam logic [AW-1:0] D_ADDR = 32'h0000_2000;
    localparam logic [DW-1:0] D_WDAT = 32'hCAFE_F00D;
    localparam logic [SW-1:0] D_SEL  = 4'hF;

    logic          clk_core = 1'b0;
    logic          rst_core;
    logic          i_cyc_i, i_stb_i, i_we_i;
    logic [SW-1:0] i_sel_i;
    logic [AW-1:0] i_addr_i;
    logic [DW-1:0] i_dat_i, i_dat_o;
    logic          i_ack_o, i_err_o;
    logic          d_cyc_i, d_stb_i, d_we_i;
    logic [SW-1:0] d_sel_i;
    logic [AW-1:0] d_addr_i;
    logic [DW-1:0] d_dat_i, d_dat_o;
    logic          d_ack_o, d_err_o;
    logic          m_cyc_o, m_stb_o, m_we_o;
    logic [SW-1:0] m_sel_o;
    logic [AW-1:0] m_addr_o;
    logic [DW-1:0] m_dat_o, m_dat_i;
    logic          m_ack_i;
    logic [1:0]    grant_o;

    wb_core_arbiter #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_core (clk_core), .rst_core (rst_core),
        .i_cyc_i  (i_cyc_i),  .i_stb_i  (i_stb_i),  .i_we_i  (i_we_i),
        .i_sel_i  (i_sel_i),  .i_addr_i (i_addr_i), .i_dat_i (i_dat_i),
        .i_dat_o  (i_dat_o),  .i_ack_o  (i_ack_o),  .i_err_o (i_err_o),
        .d_cyc_i  (d_cyc_i),  .d_stb_i  (d_stb_i),  .d_we_i  (d_we_i),
        .d_sel_i  (d_sel_i),  .d_addr_i (d_addr_i), .d_dat_i (d_dat_i),
        .d_dat_o  (d_dat_o),  .d_ack_o  (d_ack_o),  .d_err_o (d_err_o),
        .m_cyc_o  (m_cyc_o),  .m_stb_o  (m_stb_o),  .m_we_o  (m_we_o),
        .m_sel_o  (m_sel_o),  .m_addr_o (m_addr_o), .m_dat_o (m_dat_o),
        .m_dat_i  (m_dat_i),  .m_ack_i  (m_ack_i),  .grant_o (grant_o)
    );

    always #5 clk_core = ~clk_core;

    typedef struct {
        logic          rst;
        logic          ireq;
        logic          dreq;
        logic          ack;
        logic [DW-1:0] sdat;
        logic [1:0]    gnt;
    } vec_t;

    vec_t vecs[20];
    int   errors = 0;
    int   checks = 0;

    function automatic vec_t mkv(input logic r, input logic ir, input logic dr,
                                 input logic a, input logic [DW-1:0] s, input logic [1:0] g);
        vec_t v;
        v.rst = r; v.ireq = ir; v.dreq = dr; v.ack = a; v.sdat = s; v.gnt = g;
        return v;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_core);
        #1;
    endtask

    task automatic drive(input logic ic, input logic is, input logic dc, input logic ds,
                         input logic ack, input logic [DW-1:0] sdat);
        i_cyc_i = ic; i_stb_i = is;
        d_cyc_i = dc; d_stb_i = ds;
        m_ack_i = ack; m_dat_i = sdat;
    endtask

    // Slave-side expectations follow the expected owner's current inputs.
    task automatic check_bus(input string tag, input logic [1:0] eg, input logic eia,
                             input logic eda, input logic eie, input logic ede);
        logic          ecyc, estb, ewe;
        logic [SW-1:0] esel;
        logic [AW-1:0] eaddr;
        logic [DW-1:0] edat;
        ecyc = 1'b0; estb = 1'b0; ewe = 1'b0; esel = '0; eaddr = '0; edat = '0;
        if (eg == G_I) begin
            ecyc = i_cyc_i; estb = i_stb_i; ewe = i_we_i;
            esel = i_sel_i; eaddr = i_addr_i; edat = i_dat_i;
        end else if (eg == G_D) begin
            ecyc = d_cyc_i; estb = d_stb_i; ewe = d_we_i;
            esel = d_sel_i; eaddr = d_addr_i; edat = d_dat_i;
        end
        chk({tag, ".grant"}, DW'(grant_o), DW'(eg));
        chk({tag, ".m_cyc"}, DW'(m_cyc_o), DW'(ecyc));
        chk({tag, ".m_stb"}, DW'(m_stb_o), DW'(estb));
        chk({tag, ".m_we"},  DW'(m_we_o),  DW'(ewe));
        chk({tag, ".m_sel"}, DW'(m_sel_o), DW'(esel));
        chk({tag, ".m_addr"}, m_addr_o, eaddr);
        chk({tag, ".m_dat"},  m_dat_o,  edat);
        chk({tag, ".i_ack"}, DW'(i_ack_o), DW'(eia));
        chk({tag, ".d_ack"}, DW'(d_ack_o), DW'(eda));
        chk({tag, ".i_err"}, DW'(i_err_o), DW'(eie));
        chk({tag, ".d_err"}, DW'(d_err_o), DW'(ede));
    endtask

    initial begin
        rst_core = 1'b1;
        i_we_i = 1'b0; i_sel_i = I_SEL; i_addr_i = I_ADDR; i_dat_i = I_WDAT;
        d_we_i = 1'b1; d_sel_i = D_SEL; d_addr_i = D_ADDR; d_dat_i = D_WDAT;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);

        vecs[0]  = mkv(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  G_NONE);
        vecs[1]  = mkv(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  G_NONE);
        vecs[2]  = mkv(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  G_I);
        vecs[3]  = mkv(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  G_I);
        vecs[4]  = mkv(1'b0, 1'b1, 1'b0, 1'b1, 32'h13, G_I);
        vecs[5]  = mkv(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  G_NONE);
        vecs[6]  = mkv(1'b0, 1'b1, 1'b1, 1'b0, 32'h0,  G_NONE);
        vecs[7]  = mkv(1'b0, 1'b1, 1'b1, 1'b1, 32'h0,  G_D);
        vecs[8]  = mkv(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  G_NONE);
        vecs[9]  = mkv(1'b0, 1'b1, 1'b0, 1'b1, 32'h55, G_I);
        vecs[10] = mkv(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  G_NONE);
        vecs[11] = mkv(1'b0, 1'b1, 1'b1, 1'b0, 32'h0,  G_NONE);
        vecs[12] = mkv(1'b0, 1'b1, 1'b1, 1'b1, 32'hA1, G_D);
        vecs[13] = mkv(1'b0, 1'b1, 1'b1, 1'b0, 32'h0,  G_NONE);
        vecs[14] = mkv(1'b0, 1'b1, 1'b1, 1'b1, 32'hA2, G_ALT);
        vecs[15] = mkv(1'b0, 1'b1, 1'b1, 1'b0, 32'h0,  G_NONE);
        vecs[16] = mkv(1'b0, 1'b1, 1'b1, 1'b1, 32'hA3, G_D);
        vecs[17] = mkv(1'b0, 1'b1, 1'b1, 1'b0, 32'h0,  G_NONE);
        vecs[18] = mkv(1'b0, 1'b1, 1'b1, 1'b1, 32'hA4, G_ALT);
        vecs[19] = mkv(1'b0, 1'b0, 1'b0, 1'b1, 32'hEE, G_NONE);

        tick();
        tick();

        for (int i = 0; i < 20; i++) begin
            rst_core = vecs[i].rst;
            drive(vecs[i].ireq, vecs[i].ireq, vecs[i].dreq, vecs[i].dreq, vecs[i].ack, vecs[i].sdat);
            #1;
            check_bus($sformatf("vec%0d", i), vecs[i].gnt,
                      vecs[i].ack && (vecs[i].gnt == G_I),
                      vecs[i].ack && (vecs[i].gnt == G_D), 1'b0, 1'b0);
            chk($sformatf("vec%0d.i_dat", i), i_dat_o, vecs[i].sdat);
            chk($sformatf("vec%0d.d_dat", i), d_dat_o, vecs[i].sdat);
            tick();
        end

        // Watchdog: D never acked, error on the 16th granted cycle, then I served.
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, '0);
        #1; check_bus("to_req", G_NONE, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        for (int k = 1; k <= TMO; k++) begin
            #1; check_bus($sformatf("to_g%0d", k), G_D, 1'b0, 1'b0, 1'b0, k == TMO); tick();
        end
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        #1; check_bus("to_after", G_NONE, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h77);
        #1; check_bus("to_i_ack", G_I, 1'b1, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        #1; check_bus("to_idle", G_NONE, 1'b0, 1'b0, 1'b0, 1'b0); tick();

        // Master abort: D drops cyc two cycles into the grant; the late ack is swallowed.
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, '0);
        #1; check_bus("ab_req", G_NONE, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        #1; check_bus("ab_g1", G_D, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        #1; check_bus("ab_g2", G_D, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        #1; check_bus("ab_drop", G_D, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h99);
        #1; check_bus("ab_late", G_NONE, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);

        // Ack on the last watchdog cycle wins over the error.
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, '0);
        #1; check_bus("co_req", G_NONE, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        for (int k = 1; k < TMO; k++) begin
            #1; check_bus($sformatf("co_g%0d", k), G_D, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        end
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h42);
        #1; check_bus("co_ack", G_D, 1'b0, 1'b1, 1'b0, 1'b0); tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        #1; check_bus("co_idle", G_NONE, 1'b0, 1'b0, 1'b0, 1'b0); tick();

        // Reset in the middle of an I grant; the watchdog restarts from zero afterwards.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        #1; check_bus("rs_req", G_NONE, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        #1; check_bus("rs_g1", G_I, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        rst_core = 1'b1;
        #1; check_bus("rs_pre", G_I, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        #1; check_bus("rs_in", G_NONE, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_core = 1'b0;
        tick();
        for (int k = 1; k <= TMO; k++) begin
            #1; check_bus($sformatf("rs_g%0d", k), G_I, 1'b0, 1'b0, k == TMO, 1'b0); tick();
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        #1; check_bus("rs_idle", G_NONE, 1'b0, 1'b0, 1'b0, 1'b0); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
